// File: rtl/cpu_debug_ctrl.sv
// Run/halt/single-step debug controller: breakpoints, halted register readout, saturating counters.
// Optional step watchdog is built only when DBG_WATCHDOG_EN is defined.
module cpu_debug_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_BP      = 4,
  parameter int unsigned REG_AW      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned WDOG_CYCLES = 1024,
  localparam int unsigned BP_IW      = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [15:0]       step_count,
  input  logic              bp_wr_en,
  input  logic [BP_IW-1:0]  bp_wr_idx,
  input  logic [ADDR_W-1:0] bp_wr_addr,
  input  logic              bp_wr_valid,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              retire_valid,
  output logic              cpu_en,
  output logic              halted,
  output logic [2:0]        halt_cause,
  output logic [BP_IW-1:0]  bp_hit_idx,
  input  logic              dbg_rd_req,
  input  logic [REG_AW-1:0] dbg_rd_idx,
  output logic [REG_AW-1:0] dbg_reg_addr,
  input  logic [DATA_W-1:0] dbg_reg_data,
  output logic              dbg_rd_valid,
  output logic [DATA_W-1:0] dbg_rd_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count
);

  typedef enum logic [1:0] {ST_HALTED, ST_RUN, ST_STEP, ST_READ} state_t;
  typedef enum logic [2:0] {
    CAUSE_RESET   = 3'd0,
    CAUSE_HOST    = 3'd1,
    CAUSE_BP      = 3'd2,
    CAUSE_STEP    = 3'd3,
    CAUSE_TIMEOUT = 3'd4
  } cause_t;

  if (NUM_BP < 1 || NUM_BP > 16 || WDOG_CYCLES < 1) begin : g_param_check
    $error("cpu_debug_ctrl: unsupported parameter values");
  end

  state_t             state, state_nx;
  cause_t             cause, cause_nx;
  logic [BP_IW-1:0]   hit_idx, hit_idx_nx;
  logic [REG_AW-1:0]  reg_addr_nx;
  logic [15:0]        remaining, remaining_nx;
  logic               rd_go, rd_capture;
  logic [ADDR_W-1:0]  bp_addr [NUM_BP];
  logic [NUM_BP-1:0]  bp_valid;
  logic               bp_match;
  logic [BP_IW-1:0]   bp_idx;
  logic               wdog_expired;

  assign halt_cause = cause;
  assign bp_hit_idx = hit_idx;

`ifdef DBG_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog;

  assign wdog_expired = (wdog == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   wdog <= '0;
    else if (state != ST_STEP || retire_valid) wdog <= '0;
    else                                       wdog <= wdog + 1'b1;
  end
`else
  assign wdog_expired = 1'b0;
`endif

  // Lowest-index valid entry wins; compares against the table as it stood before this edge.
  always_comb begin
    bp_match = 1'b0;
    bp_idx   = '0;
    for (int unsigned i = 0; i < NUM_BP; i++) begin
      if (!bp_match && bp_valid[i] && bp_addr[i] == pc_in) begin
        bp_match = 1'b1;
        bp_idx   = BP_IW'(i);
      end
    end
  end

  always_comb begin
    state_nx     = state;
    cause_nx     = cause;
    hit_idx_nx   = hit_idx;
    remaining_nx = remaining;
    reg_addr_nx  = dbg_reg_addr;
    rd_go        = 1'b0;
    case (state)
      ST_HALTED: begin
        if (run_req) begin
          state_nx = ST_RUN;
        end else if (step_req) begin
          state_nx     = ST_STEP;
          remaining_nx = (step_count == 16'd0) ? 16'd1 : step_count;
        end else if (dbg_rd_req) begin
          state_nx    = ST_READ;
          reg_addr_nx = dbg_rd_idx;
        end
      end
      ST_RUN, ST_STEP: begin
        if (halt_req) begin
          state_nx = ST_HALTED;
          cause_nx = CAUSE_HOST;
        end else if (retire_valid && bp_match) begin
          state_nx   = ST_HALTED;
          cause_nx   = CAUSE_BP;
          hit_idx_nx = bp_idx;
        end else if (state == ST_STEP && retire_valid) begin
          if (remaining == 16'd1) begin
            state_nx = ST_HALTED;
            cause_nx = CAUSE_STEP;
          end else begin
            remaining_nx = remaining - 16'd1;
          end
        end else if (state == ST_STEP && wdog_expired) begin
          state_nx = ST_HALTED;
          cause_nx = CAUSE_TIMEOUT;
        end
      end
      ST_READ: begin
        state_nx = ST_HALTED;
        rd_go    = 1'b1;
      end
      default: state_nx = ST_HALTED;
    endcase
  end

  // Readout lags READ by one extra stage: core read data arrives a cycle after the address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_HALTED;
      cause        <= CAUSE_RESET;
      hit_idx      <= '0;
      remaining    <= '0;
      dbg_reg_addr <= '0;
      cpu_en       <= 1'b0;
      halted       <= 1'b1;
      rd_capture   <= 1'b0;
      dbg_rd_valid <= 1'b0;
      dbg_rd_data  <= '0;
    end else begin
      state        <= state_nx;
      cause        <= cause_nx;
      hit_idx      <= hit_idx_nx;
      remaining    <= remaining_nx;
      dbg_reg_addr <= reg_addr_nx;
      cpu_en       <= (state_nx == ST_RUN) || (state_nx == ST_STEP);
      halted       <= (state_nx == ST_HALTED) || (state_nx == ST_READ);
      rd_capture   <= rd_go;
      dbg_rd_valid <= rd_capture;
      if (rd_capture) dbg_rd_data <= dbg_reg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_valid <= '0;
      for (int unsigned i = 0; i < NUM_BP; i++) bp_addr[i] <= '0;
    end else if (bp_wr_en && 32'(bp_wr_idx) < NUM_BP) begin
      bp_addr[bp_wr_idx]  <= bp_wr_addr;
      bp_valid[bp_wr_idx] <= bp_wr_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count  <= '0;
      retire_count <= '0;
    end else if (cnt_clr) begin
      cycle_count  <= '0;
      retire_count <= '0;
    end else begin
      if (cpu_en && cycle_count != '1)                  cycle_count  <= cycle_count + 1'b1;
      if (cpu_en && retire_valid && retire_count != '1) retire_count <= retire_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Scoreboard bench for cpu_debug_ctrl: randomized core/host stimulus against a behavioural model.
module tb_cpu_debug_ctrl;

  localparam int unsigned CW    = 8;
  localparam int unsigned WDOG  = 16;
  localparam int unsigned SATV  = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_req, halt_req, step_req, bp_wr_en, bp_wr_valid, retire_valid;
  logic [15:0] step_count;
  logic [1:0]  bp_wr_idx;
  logic [31:0] bp_wr_addr, pc_in;
  logic        cpu_en, halted, dbg_rd_req, dbg_rd_valid, cnt_clr;
  logic [2:0]  halt_cause;
  logic [1:0]  bp_hit_idx;
  logic [3:0]  dbg_rd_idx, dbg_reg_addr;
  logic [31:0] dbg_reg_data, dbg_rd_data;
  logic [CW-1:0] cycle_count, retire_count;

  cpu_debug_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_BP(4), .REG_AW(4), .CNT_W(CW),
                   .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .step_count(step_count), .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx),
    .bp_wr_addr(bp_wr_addr), .bp_wr_valid(bp_wr_valid), .pc_in(pc_in),
    .retire_valid(retire_valid), .cpu_en(cpu_en), .halted(halted), .halt_cause(halt_cause),
    .bp_hit_idx(bp_hit_idx), .dbg_rd_req(dbg_rd_req), .dbg_rd_idx(dbg_rd_idx),
    .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data), .dbg_rd_valid(dbg_rd_valid),
    .dbg_rd_data(dbg_rd_data), .cnt_clr(cnt_clr), .cycle_count(cycle_count),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  // Core register file with a one-cycle registered read port.
  logic [31:0] regs [16];
  always @(posedge clk) dbg_reg_data <= regs[dbg_reg_addr];

  typedef struct {
    logic [2:0]  cause;
    logic [1:0]  idx;
    int unsigned ret;
  } halt_exp_t;

  halt_exp_t   hq[$];
  logic [31:0] rq[$];
  logic [31:0] pc_script[$];

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] m_bpa [4];
  bit          m_bpv [4];
  int unsigned m_ret;
  logic [2:0]  m_cause;
  logic [1:0]  m_idx;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void retire_one();
    if (m_ret < SATV) m_ret++;
  endfunction

  function automatic void push_halt(input logic [2:0] cause, input logic [1:0] idx);
    halt_exp_t e;
    e.cause = cause;
    e.idx   = idx;
    e.ret   = m_ret;
    hq.push_back(e);
    m_cause = cause;
    m_idx   = idx;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_bpv[i] = 1'b0;
      m_bpa[i] = '0;
    end
    m_ret   = 0;
    m_cause = 3'd0;
    m_idx   = 2'd0;
  endfunction

  task automatic clr_in();
    run_req = 0; halt_req = 0; step_req = 0; retire_valid = 0;
    dbg_rd_req = 0; bp_wr_en = 0; cnt_clr = 0;
  endtask

  // Monitor: pops an expectation whenever the DUT presents read data or enters halt.
  initial begin : monitor
    bit        prev;
    halt_exp_t e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
      end else begin
        if (dbg_rd_valid) begin
          if (rq.size() == 0) chk("rd_unexpected", dbg_rd_valid, 0);
          else                chk("rd_data", dbg_rd_data, rq.pop_front());
        end
        if (halted && !prev) begin
          if (hq.size() == 0) begin
            chk("halt_unexpected", halted, 0);
          end else begin
            e = hq.pop_front();
            chk("halt_cause", halt_cause, e.cause);
            chk("bp_hit_idx", bp_hit_idx, e.idx);
            chk("retire_count", retire_count, e.ret);
            chk("halt_cpu_en", cpu_en, 0);
          end
        end
        prev = halted;
      end
    end
  end

  task automatic bp_write(input int idx, input logic [31:0] addr, input bit v);
    @(negedge clk);
    bp_wr_en = 1; bp_wr_idx = 2'(idx); bp_wr_addr = addr; bp_wr_valid = v;
    @(negedge clk);
    bp_wr_en = 0;
    m_bpa[idx] = addr;
    m_bpv[idx] = v;
  endtask

  task automatic counters_clear();
    @(negedge clk); cnt_clr = 1;
    @(negedge clk); cnt_clr = 0;
    m_ret = 0;
    chk("clr_cycle", cycle_count, 0);
    chk("clr_retire", retire_count, 0);
  endtask

  task automatic reg_read(input int idx);
    @(negedge clk);
    dbg_rd_req = 1; dbg_rd_idx = 4'(idx);
    rq.push_back(regs[idx]);
    @(negedge clk);
    dbg_rd_req = 0;
    chk("rd_addr", dbg_reg_addr, idx);
    chk("rd_halted", halted, 1);
    @(negedge clk);
    chk("rd_early", dbg_rd_valid, 0);
    @(negedge clk);
    chk("rd_cause_kept", halt_cause, m_cause);
  endtask

  // Acts as host plus core: starts a run or step, retires instructions and predicts the halt.
  task automatic drive(input bit step_mode, input int unsigned cnt, input int halt_at,
                       input int unsigned rprob, input bit noise);
    int unsigned rem;
    int unsigned gap;
    bit          done;
    @(negedge clk);
    if (step_mode) begin step_req = 1; step_count = 16'(cnt); end
    else           run_req = 1;
    @(negedge clk);
    clr_in();
    chk("start_en", cpu_en, 1);
    rem  = (cnt == 0) ? 1 : cnt;
    gap  = 0;
    done = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      bit          r, h;
      int          mi;
      logic [31:0] pc;
      r = ($urandom_range(99) < rprob);
      if (pc_script.size() > 0) begin
        pc = pc_script.pop_front();
        r  = 1;
      end else begin
        pc = 32'($urandom_range(7)) << 2;
      end
      h  = (cyc == halt_at);
      mi = -1;
      for (int i = 0; i < 4; i++)
        if (mi < 0 && m_bpv[i] && m_bpa[i] == pc) mi = i;
      retire_valid = r; pc_in = pc; halt_req = h;
      if (noise) begin
        run_req    = ($urandom_range(3) == 0);
        step_req   = ($urandom_range(3) == 0);
        step_count = 16'($urandom);
        dbg_rd_req = ($urandom_range(3) == 0);
        dbg_rd_idx = 4'($urandom);
      end
      if (r) retire_one();
      if (h) begin
        push_halt(3'd1, m_idx); done = 1;
      end else if (r && mi >= 0) begin
        push_halt(3'd2, 2'(mi)); done = 1;
      end else if (step_mode && r && rem == 1) begin
        push_halt(3'd3, m_idx); done = 1;
      end else if (step_mode && r) begin
        rem--;
      end
`ifdef DBG_WATCHDOG_EN
      else if (step_mode && gap + 1 == WDOG) begin
        push_halt(3'd4, m_idx); done = 1;
      end
`endif
      gap = r ? 0 : gap + 1;
      @(negedge clk);
      clr_in();
      if (!done && !cpu_en) begin
        chk("run_en", cpu_en, 1);
        done = 1;
      end
    end
    if (!done) begin
      chk("drive_timeout", cpu_en, 0);
      halt_req = 1;
      @(negedge clk);
      halt_req = 0;
    end
  endtask

  initial begin : timeout_guard
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int unsigned n;
    clr_in();
    step_count = 0; bp_wr_idx = 0; bp_wr_addr = 0; bp_wr_valid = 0;
    pc_in = 0; dbg_rd_idx = 0;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    regs[14] = 32'd8;
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_halted", halted, 1);
    chk("rst_cause", halt_cause, 0);
    chk("rst_idx", bp_hit_idx, 0);
    chk("rst_rd_valid", dbg_rd_valid, 0);
    chk("rst_cycle", cycle_count, 0);
    rst = 0;

    // Step of 3 with a retire every cycle, then a zero-length step.
    counters_clear();
    drive(1, 3, -1, 100, 0);
    chk("step3_cycles", cycle_count, 3);
    counters_clear();
    drive(1, 0, -1, 100, 0);
    chk("step0_cycles", cycle_count, 1);
    chk("step0_retires", retire_count, 1);

    // Two entries on the same PC: lowest index reported.
    bp_write(2, 32'h14, 1);
    bp_write(1, 32'h14, 1);
    pc_script = '{32'h0C, 32'h10, 32'h14};
    drive(0, 0, -1, 100, 0);

    // Host halt and breakpoint match together: host wins.
    pc_script = '{32'h14};
    drive(0, 0, 0, 100, 0);

    reg_read(14);
    reg_read(3);

    // Breakpoint written in the same cycle as a matching retire uses the old (invalid) entry.
    @(negedge clk); run_req = 1;
    @(negedge clk); run_req = 0;
    retire_valid = 1; pc_in = 32'h20; dbg_rd_req = 1; dbg_rd_idx = 4'd14;
    bp_wr_en = 1; bp_wr_idx = 2'd0; bp_wr_addr = 32'h20; bp_wr_valid = 1;
    retire_one();
    @(negedge clk);
    clr_in();
    m_bpa[0] = 32'h20; m_bpv[0] = 1'b1;
    chk("bp_old_entry", cpu_en, 1);
    retire_valid = 1; pc_in = 32'h20;
    retire_one();
    push_halt(3'd2, 2'd0);
    @(negedge clk);
    clr_in();
    chk("bp_new_entry", cpu_en, 0);

    // Step with no retires.
    @(negedge clk); step_req = 1; step_count = 16'd5;
`ifdef DBG_WATCHDOG_EN
    push_halt(3'd4, m_idx);
    @(negedge clk); clr_in();
    n = 0;
    while (cpu_en && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("wdog_len", n, WDOG);
`else
    @(negedge clk); clr_in();
    repeat (40) @(negedge clk);
    chk("nowdog_running", cpu_en, 1);
    halt_req = 1;
    push_halt(3'd1, m_idx);
    @(negedge clk); clr_in();
`endif

    // Randomized mix of breakpoint edits, runs, steps and reads.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(3))
        0: bp_write($urandom_range(3), 32'($urandom_range(7)) << 2, 1'($urandom));
        1: drive(1, $urandom_range(5), ($urandom_range(4) == 0) ? $urandom_range(6) : -1,
                 $urandom_range(100, 30), 1);
        2: drive(0, 0, $urandom_range(20), 60, 1);
        default: reg_read($urandom_range(15));
      endcase
    end

    // Saturation, then clear colliding with increment.
    for (int i = 0; i < 4; i++) bp_write(i, 32'h0, 0);
    counters_clear();
    @(negedge clk); run_req = 1;
    @(negedge clk); run_req = 0;
    for (int i = 0; i < 300; i++) begin
      retire_valid = 1; pc_in = 32'($urandom_range(7)) << 2;
      retire_one();
      if (i == 299) begin
        halt_req = 1;
        push_halt(3'd1, m_idx);
      end
      @(negedge clk);
    end
    clr_in();
    chk("sat_cycle", cycle_count, SATV);
    @(negedge clk); run_req = 1;
    @(negedge clk); run_req = 0;
    retire_valid = 1; cnt_clr = 1;
    @(negedge clk);
    clr_in();
    m_ret = 0;
    chk("clr_win_cycle", cycle_count, 0);
    chk("clr_win_retire", retire_count, 0);
    halt_req = 1;
    push_halt(3'd1, m_idx);
    @(negedge clk);
    clr_in();
    chk("post_clr_cycle", cycle_count, 1);

    // Asynchronous reset mid-run clears everything without a clock edge.
    bp_write(3, 32'h8, 1);
    @(negedge clk); run_req = 1;
    @(negedge clk); run_req = 0; retire_valid = 1; pc_in = 32'h4;
    @(negedge clk); retire_valid = 0;
    #2 rst = 1;
    #1;
    chk("arst_cpu_en", cpu_en, 0);
    chk("arst_halted", halted, 1);
    chk("arst_cause", halt_cause, 0);
    chk("arst_idx", bp_hit_idx, 0);
    chk("arst_reg_addr", dbg_reg_addr, 0);
    chk("arst_rd_data", dbg_rd_data, 0);
    chk("arst_cycle", cycle_count, 0);
    chk("arst_retire", retire_count, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    pc_script = '{32'h8};
    drive(0, 0, 2, 100, 0);

    repeat (3) @(negedge clk);
    chk("halt_queue_empty", hq.size(), 0);
    chk("read_queue_empty", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
